gbt_frame_builder: RTL and testbench

- Upstream feeder of the optical GBT e-link serializer stage.
- Accepts 96-bit payload words from ALCT trigger/readout logic through a valid/ready handshake and buffers them in a small FIFO.
- Emits one 112-bit frame per 40 MHz frame clock: header byte, sequence/status byte, then payload or idle fill.
- Holds idle/sync frames until the GBTx transmitter reports ready.

---
 rtl/gbt_frame_pkg.sv | 54 +++++
 rtl/gbt_tx_fifo.sv | 69 ++++++
 rtl/gbt_frame_builder.sv | 174 +++++++++++++++++
 tb/tb_gbt_frame_builder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gbt_frame_pkg.sv
// Shared definitions for the GBT e-link frame builder: frame layout, headers,
// FSM encoding and the PRBS-7 payload generator.
package gbt_frame_pkg;

  localparam int unsigned FRAME_W   = 112;
  localparam int unsigned PAYLOAD_W = 96;
  localparam int unsigned SEQ_W     = 4;
  localparam int unsigned PRBS_W    = 7;

  localparam logic [7:0] HDR_DATA  = 8'h5A;
  localparam logic [7:0] HDR_IDLE  = 8'hC5;
  localparam logic [7:0] HDR_SYNC  = 8'hA3;
  localparam logic [7:0] HDR_PRBS  = 8'h96;
  localparam logic [7:0] SYNC_FILL = 8'hA3;

  localparam logic [PRBS_W-1:0] PRBS_SEED = 7'h7F;

  typedef enum logic [1:0] {
    ST_WAIT_RDY = 2'b00,
    ST_SYNC     = 2'b01,
    ST_RUN      = 2'b10
  } state_e;

  // One frame as seen by the serializer; byte k of the vector drives e-link k.
  typedef struct packed {
    logic [7:0]           header;
    logic [SEQ_W-1:0]     seq;
    logic                 almost_full;
    logic [2:0]           state;
    logic [PAYLOAD_W-1:0] payload;
  } frame_t;

  typedef struct packed {
    logic [PRBS_W-1:0]    state;
    logic [PAYLOAD_W-1:0] bits;
  } prbs_step_t;

  // Advance PRBS-7 (x^7 + x^6 + 1) by 96 steps; the first generated bit lands in bits[95].
  function automatic prbs_step_t prbs7_next96(input logic [PRBS_W-1:0] seed);
    prbs_step_t       r;
    logic [PRBS_W-1:0] s;
    logic             fb;
    s      = seed;
    r.bits = '0;
    for (int i = 0; i < int'(PAYLOAD_W); i++) begin
      fb     = s[6] ^ s[5];
      r.bits = {r.bits[PAYLOAD_W-2:0], fb};
      s      = {s[5:0], fb};
    end
    r.state = s;
    return r;
  endfunction

endpackage

// File: rtl/gbt_tx_fifo.sv
// Synchronous payload FIFO with registered full/empty/ready flags and occupancy.
// Read data is presented combinationally from the head entry so a pop and its
// data are consumed on the same edge.
module gbt_tx_fifo #(
  parameter  int unsigned DEPTH = 8,
  parameter  int unsigned WIDTH = 96,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned LW    = AW + 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data_c,
  output logic             full,
  output logic             empty,
  output logic             ready,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr_c;
  logic             do_rd_c;
  logic [LW-1:0]    level_nxt_c;
  logic             full_nxt_c;

  assign do_wr_c   = wr_en & ~full;
  assign do_rd_c   = rd_en & ~empty;
  assign rd_data_c = mem[rd_ptr];

  // Next occupancy from the accepted write/pop pair.
  always_comb begin
    level_nxt_c = level;
    if (do_wr_c && !do_rd_c) begin
      level_nxt_c = level + LW'(1);
    end else if (!do_wr_c && do_rd_c) begin
      level_nxt_c = level - LW'(1);
    end
    full_nxt_c = (level_nxt_c == LW'(DEPTH));
  end

  // Pointers, occupancy and flags; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      ready  <= 1'b1;
    end else begin
      if (do_wr_c) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd_c) rd_ptr <= rd_ptr + AW'(1);
      level <= level_nxt_c;
      full  <= full_nxt_c;
      empty <= (level_nxt_c == '0);
      ready <= ~full_nxt_c;
    end
  end

  // Storage array; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clock) begin
    if (do_wr_c) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/gbt_frame_builder.sv
// GBT e-link frame builder: buffers 96-bit payload words and emits one 112-bit
// frame per frame clock (IDLE while the GBTx is not ready, SYNC burst after it
// becomes ready, then DATA/IDLE frames).
// Optional macro GBT_FRAME_PRBS_EN adds a prbs_mode input that replaces the
// RUN-state payload with a PRBS-7 test pattern.
module gbt_frame_builder
  import gbt_frame_pkg::*;
#(
  parameter  int unsigned DEPTH       = 8,
  parameter  int unsigned SYNC_FRAMES = 16,
  localparam int unsigned LVL_W       = $clog2(DEPTH) + 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [PAYLOAD_W-1:0] din,
  input  logic                 din_valid,
  output logic                 din_ready,
  input  logic                 gbt_txrdy,
`ifdef GBT_FRAME_PRBS_EN
  input  logic                 prbs_mode,
`endif
  output logic [FRAME_W-1:0]   frame_o,
  output logic [1:0]           state_o,
  output logic [LVL_W-1:0]     fifo_level,
  output logic [15:0]          drop_cnt
);

  localparam int unsigned CNT_W = 8;

  state_e               state_q;
  state_e               state_d;
  logic [CNT_W-1:0]     sync_cnt_q;
  logic [CNT_W-1:0]     sync_cnt_d;
  logic [SEQ_W-1:0]     seq_q;
  logic [SEQ_W-1:0]     seq_d;
  frame_t               frame_d;
  logic                 txrdy_meta;
  logic                 txrdy_sync;
  logic                 pop_c;
  logic [PAYLOAD_W-1:0] fifo_rd_data_c;
  logic                 fifo_full;
  logic                 fifo_empty;
`ifdef GBT_FRAME_PRBS_EN
  logic [PRBS_W-1:0]    lfsr_q;
  logic [PRBS_W-1:0]    lfsr_d;
  prbs_step_t           prbs_step_c;
`endif

  gbt_tx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PAYLOAD_W)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .wr_en     (din_valid),
    .wr_data   (din),
    .rd_en     (pop_c),
    .rd_data_c (fifo_rd_data_c),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .ready     (din_ready),
    .level     (fifo_level)
  );

  // Two-flop synchronizer for the asynchronous transmitter-ready flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      txrdy_meta <= 1'b0;
      txrdy_sync <= 1'b0;
    end else begin
      txrdy_meta <= gbt_txrdy;
      txrdy_sync <= txrdy_meta;
    end
  end

  // FSM state, sync counter, sequence number and outgoing frame registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_WAIT_RDY;
      sync_cnt_q <= '0;
      seq_q      <= '0;
      frame_o    <= {HDR_IDLE, 8'h00, {PAYLOAD_W{1'b0}}};
    end else begin
      state_q    <= state_d;
      sync_cnt_q <= sync_cnt_d;
      seq_q      <= seq_d;
      frame_o    <= frame_d;
    end
  end

  // Next state, pop request and frame contents for the current state.
  always_comb begin
    state_d             = state_q;
    sync_cnt_d          = '0;
    seq_d               = seq_q;
    pop_c               = 1'b0;
    frame_d.header      = HDR_IDLE;
    frame_d.seq         = seq_q;
    frame_d.almost_full = (fifo_level >= LVL_W'(DEPTH - 2));
    frame_d.state       = {1'b0, state_q};
    frame_d.payload     = '0;
`ifdef GBT_FRAME_PRBS_EN
    prbs_step_c = prbs7_next96(lfsr_q);
    lfsr_d      = lfsr_q;
`endif

    case (state_q)
      ST_WAIT_RDY: begin
        if (txrdy_sync) state_d = ST_SYNC;
      end
      ST_SYNC: begin
        frame_d.header  = HDR_SYNC;
        frame_d.payload = {12{SYNC_FILL}};
        if (sync_cnt_q == CNT_W'(SYNC_FRAMES - 1)) begin
          state_d = ST_RUN;
        end else begin
          sync_cnt_d = sync_cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
`ifdef GBT_FRAME_PRBS_EN
        if (prbs_mode) begin
          frame_d.header  = HDR_PRBS;
          frame_d.payload = prbs_step_c.bits;
          seq_d           = seq_q + SEQ_W'(1);
          lfsr_d          = prbs_step_c.state;
        end else
`endif
        if (!fifo_empty) begin
          pop_c           = 1'b1;
          frame_d.header  = HDR_DATA;
          frame_d.payload = fifo_rd_data_c;
          seq_d           = seq_q + SEQ_W'(1);
        end
      end
      default: begin
        state_d = ST_WAIT_RDY;
      end
    endcase

    // Loss of transmitter ready aborts any state; a later rise restarts the full sync burst.
    if (!txrdy_sync) begin
      state_d    = ST_WAIT_RDY;
      sync_cnt_d = '0;
    end

`ifdef GBT_FRAME_PRBS_EN
    if (state_q != ST_RUN && state_d == ST_RUN) lfsr_d = PRBS_SEED;
`endif
  end

`ifdef GBT_FRAME_PRBS_EN
  // PRBS generator state; reseeded on reset and whenever RUN is entered.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_q <= PRBS_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`endif

  // Saturating count of frames that could not carry queued data.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt <= '0;
    end else if (state_q != ST_RUN && fifo_full && drop_cnt != 16'hFFFF) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_gbt_frame_builder.sv
// Directed self-checking bench for gbt_frame_builder (DEPTH=8, SYNC_FRAMES=16).
module tb_gbt_frame_builder;
  import gbt_frame_pkg::*;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic [95:0]  din = '0;
  logic         din_valid = 1'b0;
  logic         din_ready;
  logic         gbt_txrdy = 1'b0;
  logic         prbs_mode = 1'b0;
  logic [111:0] frame_o;
  logic [1:0]   state_o;
  logic [3:0]   fifo_level;
  logic [15:0]  drop_cnt;

  int          checks = 0;
  int          passed = 0;
  logic [3:0]  exp_seq = '0;

  gbt_frame_builder #(.DEPTH(8), .SYNC_FRAMES(16)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .gbt_txrdy  (gbt_txrdy),
`ifdef GBT_FRAME_PRBS_EN
    .prbs_mode  (prbs_mode),
`endif
    .frame_o    (frame_o),
    .state_o    (state_o),
    .fifo_level (fifo_level),
    .drop_cnt   (drop_cnt)
  );

  always #5 clock = ~clock;

  function automatic logic [111:0] mk(input logic [7:0] h, input logic [3:0] s,
                                      input logic af, input logic [1:0] st,
                                      input logic [95:0] p);
    return {h, s, af, 1'b0, st, p};
  endfunction

  task automatic step();
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; gbt_txrdy = 1'b0; din_valid = 1'b0; din = '0;
    repeat (2) step();
    checks++; if (frame_o !== mk(8'hC5, 4'd0, 1'b0, 2'd0, '0)) $display("FAIL rst_frame: got %h expected %h", frame_o, mk(8'hC5, 4'd0, 1'b0, 2'd0, '0)); else passed++;
    checks++; if (fifo_level !== 4'd0) $display("FAIL rst_level: got %0d expected 0", fifo_level); else passed++;
    checks++; if (drop_cnt !== 16'd0) $display("FAIL rst_drop: got %0d expected 0", drop_cnt); else passed++;
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++; if (frame_o[111:104] !== 8'hC5) $display("FAIL wait_hdr: got %h expected c5", frame_o[111:104]); else passed++;
      checks++; if (state_o !== 2'd0) $display("FAIL wait_state: got %0d expected 0", state_o); else passed++;
      checks++; if (din_ready !== 1'b1) $display("FAIL wait_ready: got %b expected 1", din_ready); else passed++;
    end
  endtask

  task automatic test_sync_entry();
    gbt_txrdy = 1'b1;
    step();
    checks++; if (state_o !== 2'd0) $display("FAIL sync_lat1: state %0d expected 0", state_o); else passed++;
    step();
    checks++; if (state_o !== 2'd0) $display("FAIL sync_lat2: state %0d expected 0", state_o); else passed++;
    step();
    checks++; if (state_o !== 2'd1) $display("FAIL sync_enter: state %0d expected 1", state_o); else passed++;
    checks++; if (frame_o[111:104] !== 8'hC5) $display("FAIL sync_prev_hdr: got %h expected c5", frame_o[111:104]); else passed++;
    for (int i = 0; i < 16; i++) begin
      step();
      checks++; if (frame_o !== mk(8'hA3, 4'd0, 1'b0, 2'd1, {12{8'hA3}})) $display("FAIL sync_frame%0d: got %h expected %h", i, frame_o, mk(8'hA3, 4'd0, 1'b0, 2'd1, {12{8'hA3}})); else passed++;
    end
    checks++; if (state_o !== 2'd2) $display("FAIL run_enter: state %0d expected 2", state_o); else passed++;
    step();
    checks++; if (frame_o !== mk(8'hC5, 4'd0, 1'b0, 2'd2, '0)) $display("FAIL run_idle: got %h expected %h", frame_o, mk(8'hC5, 4'd0, 1'b0, 2'd2, '0)); else passed++;
    exp_seq = 4'd0;
  endtask

  task automatic test_back_to_back();
    din = 96'h1; din_valid = 1'b1;
    step();
    checks++; if (fifo_level !== 4'd1) $display("FAIL b2b_level1: got %0d expected 1", fifo_level); else passed++;
    checks++; if (frame_o[111:104] !== 8'hC5) $display("FAIL b2b_latency: got %h expected c5", frame_o[111:104]); else passed++;
    din = 96'h2;
    step();
    checks++; if (frame_o !== mk(8'h5A, 4'd0, 1'b0, 2'd2, 96'h1)) $display("FAIL b2b_w1: got %h expected %h", frame_o, mk(8'h5A, 4'd0, 1'b0, 2'd2, 96'h1)); else passed++;
    din = 96'h3;
    step();
    checks++; if (frame_o !== mk(8'h5A, 4'd1, 1'b0, 2'd2, 96'h2)) $display("FAIL b2b_w2: got %h expected %h", frame_o, mk(8'h5A, 4'd1, 1'b0, 2'd2, 96'h2)); else passed++;
    checks++; if (fifo_level !== 4'd1) $display("FAIL b2b_level2: got %0d expected 1", fifo_level); else passed++;
    din_valid = 1'b0;
    step();
    checks++; if (frame_o !== mk(8'h5A, 4'd2, 1'b0, 2'd2, 96'h3)) $display("FAIL b2b_w3: got %h expected %h", frame_o, mk(8'h5A, 4'd2, 1'b0, 2'd2, 96'h3)); else passed++;
    checks++; if (fifo_level !== 4'd0) $display("FAIL b2b_level0: got %0d expected 0", fifo_level); else passed++;
    step();
    checks++; if (frame_o !== mk(8'hC5, 4'd3, 1'b0, 2'd2, '0)) $display("FAIL b2b_idle: got %h expected %h", frame_o, mk(8'hC5, 4'd3, 1'b0, 2'd2, '0)); else passed++;
    exp_seq = 4'd3;
  endtask

  task automatic test_full_drop();
    int idx;
    gbt_txrdy = 1'b0;
    repeat (3) step();
    checks++; if (state_o !== 2'd0) $display("FAIL drop_wait: state %0d expected 0", state_o); else passed++;
    for (int i = 0; i < 8; i++) begin
      din = 96'(32'h100 + i); din_valid = 1'b1;
      step();
    end
    checks++; if (fifo_level !== 4'd8) $display("FAIL full_level: got %0d expected 8", fifo_level); else passed++;
    checks++; if (din_ready !== 1'b0) $display("FAIL full_ready: got %b expected 0", din_ready); else passed++;
    checks++; if (drop_cnt !== 16'd0) $display("FAIL drop_start: got %0d expected 0", drop_cnt); else passed++;
    din = 96'hDEAD;
    repeat (3) step();
    checks++; if (fifo_level !== 4'd8) $display("FAIL full_hold: got %0d expected 8", fifo_level); else passed++;
    checks++; if (drop_cnt !== 16'd3) $display("FAIL drop_count: got %0d expected 3", drop_cnt); else passed++;
    checks++; if (frame_o !== mk(8'hC5, 4'd3, 1'b1, 2'd0, '0)) $display("FAIL full_af: got %h expected %h", frame_o, mk(8'hC5, 4'd3, 1'b1, 2'd0, '0)); else passed++;
    din_valid = 1'b0;
    gbt_txrdy = 1'b1;
    idx = 0;
    for (int c = 0; c < 60 && idx < 8; c++) begin
      step();
      if (frame_o[111:104] == 8'h5A) begin
        if (idx == 0) begin
          checks++; if (drop_cnt !== 16'd22) $display("FAIL drop_total: got %0d expected 22", drop_cnt); else passed++;
        end
        checks++; if (frame_o !== mk(8'h5A, exp_seq, (8 - idx) >= 6, 2'd2, 96'(32'h100 + idx))) $display("FAIL drain%0d: got %h expected %h", idx, frame_o, mk(8'h5A, exp_seq, (8 - idx) >= 6, 2'd2, 96'(32'h100 + idx))); else passed++;
        idx++;
        exp_seq = exp_seq + 4'd1;
      end
    end
    checks++; if (idx != 8) $display("FAIL drain_count: got %0d expected 8", idx); else passed++;
    checks++; if (fifo_level !== 4'd0) $display("FAIL drain_level: got %0d expected 0", fifo_level); else passed++;
  endtask

  task automatic test_sync_abort();
    int n;
    int hdrs;
    gbt_txrdy = 1'b0;
    repeat (3) step();
    checks++; if (state_o !== 2'd0) $display("FAIL abort_wait: state %0d expected 0", state_o); else passed++;
    gbt_txrdy = 1'b1;
    n = 0;
    while (state_o != 2'd1 && n < 20) begin step(); n++; end
    checks++; if (state_o !== 2'd1) $display("FAIL abort_sync: state %0d expected 1", state_o); else passed++;
    repeat (4) step();
    gbt_txrdy = 1'b0;
    step();
    checks++; if (state_o !== 2'd1) $display("FAIL abort_hold1: state %0d expected 1", state_o); else passed++;
    step();
    checks++; if (state_o !== 2'd1) $display("FAIL abort_hold2: state %0d expected 1", state_o); else passed++;
    step();
    checks++; if (state_o !== 2'd0) $display("FAIL abort_drop: state %0d expected 0", state_o); else passed++;
    gbt_txrdy = 1'b1;
    n = 0;
    while (state_o != 2'd1 && n < 20) begin step(); n++; end
    checks++; if (state_o !== 2'd1) $display("FAIL resync_enter: state %0d expected 1", state_o); else passed++;
    n = 0; hdrs = 0;
    while (state_o == 2'd1 && n < 40) begin
      step(); n++;
      if (frame_o[111:104] == 8'hA3) hdrs++;
    end
    checks++; if (n != 16) $display("FAIL resync_len: got %0d expected 16", n); else passed++;
    checks++; if (hdrs != 16) $display("FAIL resync_frames: got %0d expected 16", hdrs); else passed++;
    checks++; if (state_o !== 2'd2) $display("FAIL resync_run: state %0d expected 2", state_o); else passed++;
  endtask

  task automatic test_seq_wrap();
    int idx;
    idx = 0;
    for (int c = 0; c < 25; c++) begin
      din_valid = (c < 17);
      din = 96'(32'h200 + c);
      step();
      if (frame_o[111:104] == 8'h5A) begin
        checks++; if (frame_o !== mk(8'h5A, exp_seq, 1'b0, 2'd2, 96'(32'h200 + idx))) $display("FAIL wrap%0d: got %h expected %h", idx, frame_o, mk(8'h5A, exp_seq, 1'b0, 2'd2, 96'(32'h200 + idx))); else passed++;
        idx++;
        exp_seq = exp_seq + 4'd1;
      end
    end
    checks++; if (idx != 17) $display("FAIL wrap_count: got %0d expected 17", idx); else passed++;
    checks++; if (frame_o !== mk(8'hC5, 4'd12, 1'b0, 2'd2, '0)) $display("FAIL wrap_idle: got %h expected %h", frame_o, mk(8'hC5, 4'd12, 1'b0, 2'd2, '0)); else passed++;
  endtask

  task automatic test_async_reset();
    din = 96'hABC; din_valid = 1'b1;
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (frame_o !== mk(8'hC5, 4'd0, 1'b0, 2'd0, '0)) $display("FAIL arst_frame: got %h expected %h", frame_o, mk(8'hC5, 4'd0, 1'b0, 2'd0, '0)); else passed++;
    checks++; if (state_o !== 2'd0) $display("FAIL arst_state: got %0d expected 0", state_o); else passed++;
    checks++; if (fifo_level !== 4'd0) $display("FAIL arst_level: got %0d expected 0", fifo_level); else passed++;
    checks++; if (din_ready !== 1'b1) $display("FAIL arst_ready: got %b expected 1", din_ready); else passed++;
    checks++; if (drop_cnt !== 16'd0) $display("FAIL arst_drop: got %0d expected 0", drop_cnt); else passed++;
    din_valid = 1'b0;
    step();
    reset_n = 1'b1;
    exp_seq = 4'd0;
  endtask

`ifdef GBT_FRAME_PRBS_EN
  task automatic test_prbs();
    logic [6:0]  s;
    logic [95:0] ref_bits;
    logic        b;
    int          n;
    prbs_mode = 1'b1;
    din_valid = 1'b1;
    din = 96'h311; step();
    din = 96'h322; step();
    din_valid = 1'b0;
    n = 0;
    while (state_o != 2'd2 && n < 40) begin step(); n++; end
    checks++; if (state_o !== 2'd2) $display("FAIL prbs_run: state %0d expected 2", state_o); else passed++;
    s = 7'h7F;
    for (int k = 0; k < 3; k++) begin
      for (int i = 95; i >= 0; i--) begin
        b = s[6] ^ s[5];
        ref_bits[i] = b;
        s = {s[5:0], b};
      end
      step();
      checks++; if (frame_o !== mk(8'h96, 4'(k), 1'b0, 2'd2, ref_bits)) $display("FAIL prbs_frame%0d: got %h expected %h", k, frame_o, mk(8'h96, 4'(k), 1'b0, 2'd2, ref_bits)); else passed++;
      checks++; if (fifo_level !== 4'd2) $display("FAIL prbs_level%0d: got %0d expected 2", k, fifo_level); else passed++;
    end
    prbs_mode = 1'b0;
    step();
    checks++; if (frame_o !== mk(8'h5A, 4'd3, 1'b0, 2'd2, 96'h311)) $display("FAIL prbs_resume: got %h expected %h", frame_o, mk(8'h5A, 4'd3, 1'b0, 2'd2, 96'h311)); else passed++;
  endtask
`endif

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sync_entry();
    test_back_to_back();
    test_full_drop();
    test_sync_abort();
    test_seq_wrap();
    test_async_reset();
`ifdef GBT_FRAME_PRBS_EN
    test_prbs();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
